// File: rtl/simplebus_mem_slave.sv
// SimpleBus memory-side slave: a 64-bit word array that answers single and
// burst reads (critical-word-first wrap), masked single writes and
// writeLast-terminated write bursts. A programmable number of idle cycles
// separates request acceptance from the first response beat.
module simplebus_mem_slave #(
    parameter int MEM_DEPTH = 256,
    parameter int BURST_LEN = 4,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_bits_addr,
    input  logic [2:0]  req_bits_size,
    input  logic [3:0]  req_bits_cmd,
    input  logic [7:0]  req_bits_wmask,
    input  logic [63:0] req_bits_wdata,
    input  logic [15:0] req_bits_user,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [3:0]  resp_bits_cmd,
    output logic [63:0] resp_bits_rdata,
    output logic [15:0] resp_bits_user
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int BW    = $clog2(BURST_LEN);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BURST_LEN - 1);

    localparam logic [3:0] CMD_READ        = 4'b0000;
    localparam logic [3:0] CMD_WRITE       = 4'b0001;
    localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
    localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
    localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;

    localparam logic [3:0] RSP_READ      = 4'b0000;
    localparam logic [3:0] RSP_READ_LAST = 4'b0110;
    localparam logic [3:0] RSP_WRITE     = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RRESP,
        S_WBURST,
        S_WRESP
    } state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [15:0]        user_q, user_d;

    logic               resp_valid_q, resp_valid_d;
    logic [3:0]         resp_cmd_q, resp_cmd_d;
    logic [63:0]        resp_rdata_q, resp_rdata_d;
    logic [15:0]        resp_user_q, resp_user_d;

    logic [63:0]        mem_q [MEM_DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   eff_idx;
    logic [3:0]         eff_cmd;
    logic [15:0]        eff_user;
    logic               enter_resp;
    logic               load_resp;
    logic [BW-1:0]      load_beat;

    logic               unused_ok;
    assign unused_ok = ^{req_bits_size, req_bits_addr[31:IDX_W+3], req_bits_addr[2:0]};

    assign req_idx = req_bits_addr[IDX_W+2:3];

    // Word index of burst beat 'beat' relative to 'start', wrapping inside the line.
    function automatic logic [IDX_W-1:0] beat_idx(input logic [IDX_W-1:0] start,
                                                  input logic [BW-1:0]    beat);
        logic [BW-1:0] off;
        off = start[BW-1:0] + beat;
        return {start[IDX_W-1:BW], off};
    endfunction

    function automatic logic is_write(input logic [3:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_WRITE_BURST);
    endfunction

    // Transaction attributes: live request fields in IDLE (zero-latency path), captured otherwise.
    always_comb begin
        eff_idx  = idx_q;
        eff_cmd  = cmd_q;
        eff_user = user_q;
        if (state_q == S_IDLE) begin
            eff_idx  = req_idx;
            eff_cmd  = req_bits_cmd;
            eff_user = req_bits_user;
        end
    end

    // Next-state, array write strobes and response-beat loading.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d      = state_q;
        lat_d        = lat_q;
        beat_d       = beat_q;
        idx_d        = idx_q;
        cmd_d        = cmd_q;
        user_d       = user_q;
        resp_valid_d = resp_valid_q;
        resp_cmd_d   = resp_cmd_q;
        resp_rdata_d = resp_rdata_q;
        resp_user_d  = resp_user_q;
        req_ready    = 1'b0;
        mem_we       = 1'b0;
        mem_widx     = req_idx;
        enter_resp   = 1'b0;
        load_resp    = 1'b0;
        load_beat    = '0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = rst;
                if (req_valid) begin
                    idx_d  = req_idx;
                    cmd_d  = req_bits_cmd;
                    user_d = req_bits_user;
                    if (req_bits_cmd == CMD_WRITE) begin
                        mem_we     = 1'b1;
                        enter_resp = 1'b1;
                    end else if (req_bits_cmd == CMD_WRITE_BURST) begin
                        mem_we  = 1'b1;
                        beat_d  = BW'(1);
                        state_d = S_WBURST;
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_LAST) begin
                    load_resp = 1'b1;
                    state_d   = is_write(cmd_q) ? S_WRESP : S_RRESP;
                end
            end
            S_RRESP: begin
                if (resp_ready) begin
                    if (cmd_q == CMD_READ_BURST && beat_q != BEAT_LAST) begin
                        beat_d    = beat_q + 1'b1;
                        load_resp = 1'b1;
                        load_beat = beat_q + 1'b1;
                    end else begin
                        resp_valid_d = 1'b0;
                        beat_d       = '0;
                        state_d      = S_IDLE;
                    end
                end
            end
            S_WBURST: begin
                req_ready = rst;
                if (req_valid) begin
                    mem_we   = 1'b1;
                    mem_widx = beat_idx(idx_q, beat_q);
                    if (req_bits_cmd == CMD_WRITE_LAST || beat_q == BEAT_LAST) begin
                        enter_resp = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_WRESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            beat_d = '0;
            if (LATENCY == 0) begin
                load_resp = 1'b1;
                state_d   = is_write(eff_cmd) ? S_WRESP : S_RRESP;
            end else begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
        end

        if (load_resp) begin
            resp_valid_d = 1'b1;
            resp_user_d  = eff_user;
            resp_rdata_d = '0;
            resp_cmd_d   = RSP_READ_LAST;
            if (is_write(eff_cmd)) begin
                resp_cmd_d = RSP_WRITE;
            end else if (eff_cmd == CMD_READ) begin
                resp_rdata_d = mem_q[eff_idx];
            end else if (eff_cmd == CMD_READ_BURST) begin
                resp_rdata_d = mem_q[beat_idx(eff_idx, load_beat)];
                resp_cmd_d   = (load_beat == BEAT_LAST) ? RSP_READ_LAST : RSP_READ;
            end
        end
    end

    // Control state and registered response; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q      <= S_IDLE;
            lat_q        <= '0;
            beat_q       <= '0;
            idx_q        <= '0;
            cmd_q        <= '0;
            user_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_cmd_q   <= '0;
            resp_rdata_q <= '0;
            resp_user_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            beat_q       <= beat_d;
            idx_q        <= idx_d;
            cmd_q        <= cmd_d;
            user_q       <= user_d;
            resp_valid_q <= resp_valid_d;
            resp_cmd_q   <= resp_cmd_d;
            resp_rdata_q <= resp_rdata_d;
            resp_user_q  <= resp_user_d;
        end
    end

    // Byte-masked array write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so its contents survive a mid-operation reset.
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (req_bits_wmask[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= req_bits_wdata[8*b +: 8];
                end
            end
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_bits_cmd   = resp_cmd_q;
    assign resp_bits_rdata = resp_rdata_q;
    assign resp_bits_user  = resp_user_q;

endmodule

// File: tb/tb_simplebus_mem_slave.sv
// Scoreboard bench for simplebus_mem_slave: expected beats are queued as
// requests are issued and compared as the slave hands them back.
module tb_simplebus_mem_slave;

    localparam int LATENCY = 2;

    localparam logic [3:0] C_RD   = 4'b0000;
    localparam logic [3:0] C_WR   = 4'b0001;
    localparam logic [3:0] C_RDB  = 4'b0010;
    localparam logic [3:0] C_WRB  = 4'b0011;
    localparam logic [3:0] C_WRL  = 4'b0111;
    localparam logic [3:0] R_RD   = 4'b0000;
    localparam logic [3:0] R_RDL  = 4'b0110;
    localparam logic [3:0] R_WR   = 4'b0101;

    typedef struct {
        logic [3:0]  cmd;
        logic [63:0] data;
        logic [15:0] user;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_bits_addr;
    logic [2:0]  req_bits_size;
    logic [3:0]  req_bits_cmd;
    logic [7:0]  req_bits_wmask;
    logic [63:0] req_bits_wdata;
    logic [15:0] req_bits_user;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_bits_cmd;
    logic [63:0] resp_bits_rdata;
    logic [15:0] resp_bits_user;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pop_cnt  = 0;
    rsp_t        exp_q[$];
    logic [63:0] model [256];

    simplebus_mem_slave #(
        .MEM_DEPTH(256),
        .BURST_LEN(4),
        .LATENCY  (LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_bits_addr  (req_bits_addr),
        .req_bits_size  (req_bits_size),
        .req_bits_cmd   (req_bits_cmd),
        .req_bits_wmask (req_bits_wmask),
        .req_bits_wdata (req_bits_wdata),
        .req_bits_user  (req_bits_user),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_bits_cmd  (resp_bits_cmd),
        .resp_bits_rdata(resp_bits_rdata),
        .resp_bits_user (resp_bits_user)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] widx(input logic [31:0] addr);
        return addr[10:3];
    endfunction

    function automatic logic [7:0] bidx(input logic [7:0] start, input int beat);
        logic [1:0] off;
        off = start[1:0] + 2'(beat);
        return {start[7:2], off};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Drive one request; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send(input logic [3:0] cmd, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        input logic [15:0] user);
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 0;
        req_valid      = 1'b1;
        req_bits_cmd   = cmd;
        req_bits_addr  = addr;
        req_bits_wdata = wdata;
        req_bits_wmask = wmask;
        req_bits_user  = user;
        req_bits_size  = 3'd3;
        while (!done) begin
            @(negedge clk);
            if (req_ready) done = 1;
            @(posedge clk);
            #1;
            if (!done) begin
                cyc++;
                if (cyc > 200) begin
                    check("req_timeout", 64'd0, 64'd1);
                    done = 1;
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] wd,
                            input logic [7:0] m, input logic [15:0] user);
        model[widx(addr)] = merge(model[widx(addr)], wd, m);
        exp_q.push_back('{cmd: R_WR, data: 64'd0, user: user});
        send(C_WR, addr, wd, m, user);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [15:0] user);
        exp_q.push_back('{cmd: R_RDL, data: model[widx(addr)], user: user});
        send(C_RD, addr, 64'd0, 8'd0, user);
    endtask

    task automatic do_read_burst(input logic [31:0] addr, input logic [15:0] user);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back('{cmd: (b == 3) ? R_RDL : R_RD,
                              data: model[bidx(widx(addr), b)], user: user});
        end
        send(C_RDB, addr, 64'd0, 8'd0, user);
    endtask

    // Wait for the scoreboard to empty, optionally toggling resp_ready each cycle.
    task automatic drain(input bit toggle);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            if (toggle) resp_ready = ~resp_ready;
            cyc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compares handshaken beats against the scoreboard and
    // checks that a stalled beat stays put.
    initial begin
        bit   have_held;
        rsp_t held;
        rsp_t e;
        have_held = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                have_held = 0;
            end else begin
                if (have_held) begin
                    check("hold_valid", 64'(resp_valid), 64'd1);
                    check("hold_cmd",   64'(resp_bits_cmd), 64'(held.cmd));
                    check("hold_data",  resp_bits_rdata, held.data);
                    check("hold_user",  64'(resp_bits_user), 64'(held.user));
                end
                if (resp_valid && resp_ready) begin
                    have_held = 0;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(resp_bits_cmd), 64'hdead);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_cmd",  64'(resp_bits_cmd), 64'(e.cmd));
                        check("rsp_data", resp_bits_rdata, e.data);
                        check("rsp_user", 64'(resp_bits_user), 64'(e.user));
                    end
                    pop_cnt++;
                end else if (resp_valid) begin
                    have_held = 1;
                    held = '{cmd: resp_bits_cmd, data: resp_bits_rdata, user: resp_bits_user};
                end else begin
                    have_held = 0;
                end
            end
        end
    end

    initial begin
        int cnt;
        int base;
        rst            = 1'b0;
        req_valid      = 1'b0;
        req_bits_addr  = '0;
        req_bits_size  = '0;
        req_bits_cmd   = '0;
        req_bits_wmask = '0;
        req_bits_wdata = '0;
        req_bits_user  = '0;
        resp_ready     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_cmd",   64'(resp_bits_cmd), 64'd0);
        check("rst_resp_rdata", resp_bits_rdata, 64'd0);
        check("rst_resp_user",  64'(resp_bits_user), 64'd0);
        rst = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Full write with latency measurement, then read back.
        do_write(32'h40, 64'h1122334455667788, 8'hFF, 16'h00A5);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!resp_valid && cnt < 50);
        check("write_latency", 64'(cnt), 64'(LATENCY + 1));
        drain(0);
        do_read(32'h40, 16'h0101);
        drain(0);

        // Partial write, then read and an aliased read of the same word.
        do_write(32'h40, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 16'h0102);
        drain(0);
        do_read(32'h40, 16'h0103);
        drain(0);
        check("model_partial", model[8'h08], 64'h11223344FFFFFFFF);
        do_read(32'h840, 16'h0104);
        drain(0);

        // Preload a line and read it critical-word-first, free-running then stalled.
        for (int i = 0; i < 4; i++) begin
            do_write(32'h80 + 32'(i * 8), 64'hA0 + 64'(i), 8'hFF, 16'h0200 + 16'(i));
            drain(0);
        end
        do_read_burst(32'h90, 16'h0B00);
        drain(0);
        do_read_burst(32'h90, 16'h0B01);
        drain(1);

        // Four-beat write burst ended by writeLast, then burst read of the line.
        exp_q.push_back('{cmd: R_WR, data: 64'd0, user: 16'h0C00});
        for (int k = 0; k < 4; k++) begin
            model[bidx(8'h20, k)] = 64'(k + 1);
            send((k == 3) ? C_WRL : C_WRB, 32'h100, 64'(k + 1), 8'hFF, 16'h0C00);
        end
        drain(0);
        repeat (5) @(posedge clk);
        #1;
        check("wburst_single_resp", 64'(resp_valid), 64'd0);
        do_read_burst(32'h100, 16'h0C01);
        drain(0);

        // Two-beat write burst ended early by writeLast, starting mid-line.
        exp_q.push_back('{cmd: R_WR, data: 64'd0, user: 16'h0D00});
        model[8'h21] = 64'h55;
        send(C_WRB, 32'h108, 64'h55, 8'hFF, 16'h0D00);
        model[8'h22] = 64'h66;
        send(C_WRL, 32'h1F8, 64'h66, 8'hFF, 16'h0D00);
        drain(0);
        do_read(32'h108, 16'h0D01);
        drain(0);
        do_read(32'h110, 16'h0D02);
        drain(0);

        // Unknown command answers a single zero readLast beat.
        exp_q.push_back('{cmd: R_RDL, data: 64'd0, user: 16'h0E00});
        send(4'b0101, 32'h40, 64'd0, 8'd0, 16'h0E00);
        drain(0);

        // Reset in the middle of a read burst.
        base = pop_cnt;
        do_read_burst(32'h80, 16'h0F00);
        cnt = 0;
        while (pop_cnt < base + 2 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("burst_reached_beat2", 64'(pop_cnt - base), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_resp_cmd",   64'(resp_bits_cmd), 64'd0);
        check("midrst_req_ready",  64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        do_read(32'h40, 16'h1000);
        drain(0);
        do_read(32'h98, 16'h1001);
        drain(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
